// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable multi-channel clock divider.
// One fast clock in, NUM_CH independent divided clocks plus matching
// single-cycle ticks (clock enables) out. Each channel's divisor is written
// into a shadow register and copied to the active register only at a period
// boundary (or sync), so a divisor change never produces a runt pulse.
//
// Ports:
//   clk_in   - fast input clock, all logic on its rising edge
//   reset_n  - asynchronous active-low reset
//   en       - per-channel run enable
//   sync     - restart all running channels in phase
//   wr_en    - divisor write strobe
//   wr_ch    - channel index for the write (out-of-range index is ignored)
//   wr_div   - new divisor value
//   clk_out  - divided clocks (registered)
//   tick     - one-cycle pulse coincident with each clk_out rising edge
//   pend     - shadow divisor differs from the active one

// Per-channel divider. High for floor(N/2) cycles, low for ceil(N/2).
module clk_div_ch #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wr_div,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_pend
);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  logic [CNT_W-1:0] r_shadow, r_active, r_cnt;
  logic             r_clk, r_tick;

  logic             w_run, w_bnd, w_sh_ok;
  logic [CNT_W-1:0] w_cnt_inc;

  // A divisor below 2 cannot form a period, so such a channel sits idle.
  assign w_run     = i_en && (r_active >= TWO);
  assign w_bnd     = (r_cnt == r_active - ONE);
  assign w_sh_ok   = (r_shadow >= TWO);
  assign w_cnt_inc = r_cnt + ONE;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= DEF;
      r_active <= DEF;
      r_cnt    <= DEF - ONE;
      r_clk    <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      // Loads below read the pre-edge shadow, so a write on a boundary/sync
      // edge is picked up one period later.
      if (i_wr) r_shadow <= i_wr_div;

      if (!w_run) begin
        // Prime cnt to the last count so the first enabled edge is a boundary.
        r_active <= r_shadow;
        r_cnt    <= r_shadow - ONE;
        r_clk    <= 1'b0;
        r_tick   <= 1'b0;
      end else if (i_sync || w_bnd) begin
        // A sub-2 shadow lands in active here and the channel idles next edge.
        r_active <= r_shadow;
        r_cnt    <= '0;
        r_clk    <= w_sh_ok;
        r_tick   <= w_sh_ok;
      end else begin
        r_cnt    <= w_cnt_inc;
        r_clk    <= (w_cnt_inc < (r_active >> 1));
        r_tick   <= 1'b0;
      end
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;
  assign o_pend = (r_shadow != r_active);
endmodule

module clk_div_prog #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);
  logic [NUM_CH-1:0] w_wr;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // Indices >= NUM_CH match no channel, so those writes drop out here.
    assign w_wr[c] = wr_en && (wr_ch == CH_W'(c));

    clk_div_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in   (clk_in),
      .reset_n  (reset_n),
      .i_en     (en[c]),
      .i_sync   (sync),
      .i_wr     (w_wr[c]),
      .i_wr_div (wr_div),
      .o_clk    (clk_out[c]),
      .o_tick   (tick[c]),
      .o_pend   (pend[c])
    );
  end
endmodule

// File: tb/tb_clk_div_prog.sv
// Testbench for clk_div_prog. Three channels so that an out-of-range write
// index exists. Reference model tracks each channel as "period running or
// not" plus a phase position inside the period; outputs are derived from
// that phase (high while phase < N/2, tick at phase 0).
module tb_clk_div_prog;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int DEF    = 4;
  localparam int CH_W   = 2;

  logic              clk_in = 1'b0;
  logic              reset_n = 1'b0;
  logic [NUM_CH-1:0] en = '1;
  logic              sync = 1'b0;
  logic              wr_en = 1'b0;
  logic [CH_W-1:0]   wr_ch = '0;
  logic [CNT_W-1:0]  wr_div = '0;
  logic [NUM_CH-1:0] clk_out, tick, pend;

  clk_div_prog #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF), .CH_W(CH_W)
  ) dut (
    .clk_in(clk_in), .reset_n(reset_n), .en(en), .sync(sync),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
    .clk_out(clk_out), .tick(tick), .pend(pend)
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_pass = 0;

  int m_sh  [NUM_CH];
  int m_act [NUM_CH];
  int m_ph  [NUM_CH];
  bit m_on  [NUM_CH];

  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_sh[c] = DEF; m_act[c] = DEF; m_ph[c] = 0; m_on[c] = 1'b0;
    end
  endtask

  // One rising edge of the model, using the inputs held across the edge.
  task automatic m_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      int  old_sh = m_sh[c];
      bit  run    = en[c] && (m_act[c] >= 2);
      bit  bnd    = !m_on[c] || (m_ph[c] == m_act[c] - 1);
      if (!run) begin
        m_act[c] = old_sh; m_on[c] = 1'b0; m_ph[c] = 0;
      end else if (sync || bnd) begin
        m_act[c] = old_sh; m_on[c] = (old_sh >= 2); m_ph[c] = 0;
      end else begin
        m_ph[c]++;
      end
      if (wr_en && (int'(wr_ch) == c)) m_sh[c] = int'(wr_div);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NUM_CH-1:0] ec, et, ep;
    for (int c = 0; c < NUM_CH; c++) begin
      ec[c] = m_on[c] && (m_ph[c] < m_act[c] / 2);
      et[c] = m_on[c] && (m_ph[c] == 0);
      ep[c] = (m_sh[c] != m_act[c]);
    end
    n_chk += 3;
    assert (clk_out === ec) n_pass++;
    else $error("FAIL %s clk_out got %b want %b", tag, clk_out, ec);
    assert (tick === et) n_pass++;
    else $error("FAIL %s tick got %b want %b", tag, tick, et);
    assert (pend === ep) n_pass++;
    else $error("FAIL %s pend got %b want %b", tag, pend, ep);
  endtask

  task automatic step(input string tag);
    @(posedge clk_in);
    m_edge();
    #1 check_all(tag);
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) step(tag);
  endtask

  task automatic wr(input int ch, input int div, input string tag);
    wr_en = 1'b1; wr_ch = CH_W'(ch); wr_div = CNT_W'(div);
    step(tag);
    wr_en = 1'b0;
  endtask

  // Advance until the next edge is a period boundary of channel c.
  task automatic wait_bnd(input int c, input string tag);
    int k = 0;
    while (!(m_on[c] && m_ph[c] == m_act[c] - 1) && k < 600) begin
      step(tag); k++;
    end
    n_chk++;
    assert (k < 600) n_pass++;
    else $error("FAIL %s timeout waiting boundary ch%0d got %0d want <600", tag, c, k);
  endtask

  initial begin
    // Reset / default: all channels 1,1,0,0 from the first edge.
    m_reset();
    #12 reset_n = 1'b1;
    check_all("reset");
    run(12, "default");

    // Odd divisor written mid-period on ch0.
    step("pre_odd");
    wr(0, 3, "wr3");
    run(12, "odd");

    // Write to an out-of-range channel index is dropped.
    wr(3, 9, "wr_oob");
    run(6, "oob");

    // Extremes.
    wr(1, 2, "wr2");
    run(8, "div2");
    wr(0, 255, "wr255");
    wait_bnd(0, "to255");
    run(520, "div255");
    wr(0, 1, "wr1");
    run(260, "div1");
    wr(1, 0, "wr0");
    run(8, "div0");
    wr(0, 4, "re4_0");
    wr(1, 4, "re4_1");
    run(10, "restart");

    // Write landing exactly on a boundary edge.
    wait_bnd(0, "to_bnd");
    wr(0, 6, "wr_at_bnd");
    run(20, "bnd6");

    // Sync: ch0 div 4, ch1 div 5, out of phase, then one sync pulse.
    wr(0, 4, "s_wr0");
    wr(1, 5, "s_wr1");
    run(23, "s_pre");
    sync = 1'b1;
    step("sync");
    sync = 1'b0;
    run(42, "s_post");

    // Enable drop during the high phase of ch1, then re-enable.
    wr(1, 6, "e_wr");
    wait_bnd(1, "e_bnd");
    step("e_hi");
    en[1] = 1'b0;
    step("en_drop");
    run(3, "en_off");
    en[1] = 1'b1;
    step("en_rise");
    run(10, "en_on");

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      int r;
      for (int c = 0; c < NUM_CH; c++) en[c] = ($urandom % 8) != 0;
      sync  = ($urandom % 32) == 0;
      wr_en = ($urandom % 6) == 0;
      wr_ch = CH_W'($urandom % 4);
      r = $urandom % 8;
      wr_div = (r == 0) ? 8'd0 : (r == 1) ? 8'd1 : (r == 2) ? 8'd2
             : CNT_W'($urandom_range(3, 12));
      step("rand");
    end
    en = '1; sync = 1'b0; wr_en = 1'b0;
    run(30, "settle");

    // Asynchronous reset mid-period.
    @(posedge clk_in);
    m_edge();
    #2 reset_n = 1'b0;
    #1 m_reset();
    check_all("async_rst");
    @(posedge clk_in);
    #1 check_all("in_rst");
    reset_n = 1'b1;
    run(12, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Programmable multi-channel clock divider producing `NUM_CH` independent divided clocks and matching single-cycle tick pulses from one fast input clock. Each channel's divisor is written at run time through a shadow-register port and takes effect only at that channel's period boundary, so there are no runt pulses. Sits in the clock/timing section next to the fixed divide-by-4 generator. Feeds slower peripheral logic, either as a derived clock or, preferably, as a `tick` clock-enable in the `clk_in` domain.

## Interface
- `NUM_CH`, 2: number of independent divider channels (≥1).
- `CNT_W`, 8: divisor and counter width; max divisor 2^CNT_W−1.
- `DEFAULT_DIV`, 4: divisor loaded into every channel at reset (2 ≤ value ≤ 2^CNT_W−1).
- `CH_W`, derived: max(1, $clog2(NUM_CH)).

Ports:
- `clk_in` input 1: single clock; all logic on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `en` input NUM_CH: per-channel run enable.
- `sync` input 1: restarts all running channels in phase.
- `wr_en` input 1: divisor write strobe.
- `wr_ch` input CH_W: channel index for the write.
- `wr_div` input CNT_W: new divisor value.
- `clk_out` output NUM_CH: divided clocks, registered.
- `tick` output NUM_CH: one-`clk_in`-cycle pulse coincident with each `clk_out` rising edge.
- `pend` output NUM_CH: shadow divisor differs from active divisor (update waiting).

## Operation
- Per channel: `shadow` (CNT_W), `active` (CNT_W), `cnt` (CNT_W), `clk_out` and `tick` flops.
- Write: when `wr_en`=1 and `wr_ch` < NUM_CH, `shadow[wr_ch]` <= `wr_div` at the edge. When `wr_ch` ≥ NUM_CH, the write is ignored.
- The channel is **running** when `en`=1 and `active` ≥ 2. Otherwise it is **idle**.
- Next-state priority per edge is: reset, then idle, then sync, then boundary, then count.
  - **Idle:** `active` <= `shadow`; `cnt` <= `shadow`−1 (mod 2^CNT_W); `clk_out` <= 0; `tick` <= 0.
  - **Sync** (`sync`=1, channel running): `active` <= `shadow`. If the new value is ≥2: `cnt` <= 0, `clk_out` <= 1, `tick` <= 1. If it is <2, the channel goes idle next cycle with outputs 0.
  - **Boundary** (`cnt` == `active`−1): `active` <= `shadow`; `cnt` <= 0. If `shadow` ≥ 2: `clk_out` <= 1, `tick` <= 1. Otherwise `clk_out` <= 0, `tick` <= 0.
  - **Count:** `cnt` <= `cnt`+1; `clk_out` <= (`cnt`+1 < `active`/2); `tick` <= 0.
- Duty cycle: high for floor(N/2) cycles, low for ceil(N/2) cycles. Exactly 50% for even N.
- A write landing on the same edge as a boundary or sync is not seen by that load. The old `shadow` is used, and the new value applies at the following boundary.
- Writing a divisor of 0 or 1 stops the channel cleanly at its next boundary, with `clk_out` low.
- `pend` = (`shadow` != `active`), combinational from registers.

## Timing
- Reset (`reset_n`=0, async) sets, for every channel: `shadow`=`active`=DEFAULT_DIV, `cnt`=DEFAULT_DIV−1, `clk_out`=0, `tick`=0, `pend`=0.
- First `clk_in` edge after `reset_n` rises, with `en`=1: boundary, so `clk_out`=1 and `tick`=1. Latency from reset release to the first rising output is one cycle.
- `en` 0→1: the first output high and tick occur on the first edge sampling `en`=1.
- `en` 1→0: `clk_out` drops on the next edge, even mid-high-phase. `cnt` is re-primed so re-enable restarts cleanly.
- Divisor change latency: from the write edge to the end of the current period, at most `active` cycles. There is no partial period.
- `tick` is never asserted on two consecutive cycles except when `active`=2 is impossible to violate. At N=2, tick is asserted every 2 cycles.
- The counter never exceeds `active`−1. At `active`=2^CNT_W−1, wrap occurs at the all-ones−1 value.
- Reset mid-period aborts immediately with outputs low. No state survives.

## Test plan
- **Reset/default:** release `reset_n` with `en`=11 and DEFAULT_DIV=4. Both `clk_out` read 1,1,0,0 repeating from the first edge, and `tick` is high on cycles 1, 5, 9.
- **Odd divisor:** write 3 to ch0 mid-period. `pend[0]`=1 until the boundary, then `clk_out[0]` reads 1,0,0 repeating and `tick` every 3 cycles. ch1 is unaffected.
- **Extremes:** `wr_div`=2 gives a toggle each cycle. `wr_div`=255 gives 127 high / 128 low. `wr_div`=1 or 0 makes `clk_out` go low at the next boundary and stay low, with `tick`=0.
- **Write at boundary:** write 6 on the exact boundary edge of a 4-period. One more 4-cycle period follows, then 6-cycle periods.
- **Sync:** run ch0 at div 4 and ch1 at div 5 out of phase, then pulse `sync` for 1 cycle. Both show `tick`=1 and `clk_out`=1 on the next edge, with rising edges aligned every 20 cycles.
- **Enable/reset abort:** drop `en[1]` during the high phase, so `clk_out[1]`=0 the next edge. Re-raise it and `tick[1]` is high on the first edge. Assert `reset_n`=0 asynchronously mid-period and all outputs go 0 immediately.
